gpr_regfile: RTL

//  32 x 32-bit general-purpose register file of the single-issue CPU. Sits directly

---
 rtl/gpr_regfile.sv | 64 ++++++
 1 files changed

// File: rtl/gpr_regfile.sv
// gpr_regfile: 32x32 general-purpose register file, two read ports with
// optional write-through bypass, a debug read port and a committed-write counter.
module gpr_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] regs [DEPTH];
   logic              we;
   logic              fwd1;
   logic              fwd2;

   assign we = RegWrite && !reset && (A3 != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         wr_count <= '0;
      end else if (we) begin
         regs[A3] <= WD;
         wr_count <= wr_count + CNT_ONE;
      end
   end

   // Forwarding covers the WB-to-decode hazard in the same cycle.
   assign fwd1 = (BYPASS != 0) && we && (A1 == A3);
   assign fwd2 = (BYPASS != 0) && we && (A2 == A3);

   always_comb begin
      RD1 = '0;
      RD2 = '0;
      dbg_data = '0;
      if (!reset && (A1 != '0)) begin
         RD1 = fwd1 ? WD : regs[A1];
      end
      if (!reset && (A2 != '0)) begin
         RD2 = fwd2 ? WD : regs[A2];
      end
      if (!reset && (dbg_addr != '0)) begin
         dbg_data = regs[dbg_addr];
      end
   end

endmodule
